// File: rtl/compressor_mul30.sv
// Bit-heap compressor for a 30x30 unsigned partial-product array: 59 weighted
// columns are reduced with 3:2 counters, summed by a 60-bit CPA and registered.
module compressor_mul30 (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:0]  src0,  input  logic [1:0]  src1,  input  logic [2:0]  src2,
  input  logic [3:0]  src3,  input  logic [4:0]  src4,  input  logic [5:0]  src5,
  input  logic [6:0]  src6,  input  logic [7:0]  src7,  input  logic [8:0]  src8,
  input  logic [9:0]  src9,  input  logic [10:0] src10, input  logic [11:0] src11,
  input  logic [12:0] src12, input  logic [13:0] src13, input  logic [14:0] src14,
  input  logic [15:0] src15, input  logic [16:0] src16, input  logic [17:0] src17,
  input  logic [18:0] src18, input  logic [19:0] src19, input  logic [20:0] src20,
  input  logic [21:0] src21, input  logic [22:0] src22, input  logic [23:0] src23,
  input  logic [24:0] src24, input  logic [25:0] src25, input  logic [26:0] src26,
  input  logic [27:0] src27, input  logic [28:0] src28, input  logic [29:0] src29,
  input  logic [28:0] src30, input  logic [27:0] src31, input  logic [26:0] src32,
  input  logic [25:0] src33, input  logic [24:0] src34, input  logic [23:0] src35,
  input  logic [22:0] src36, input  logic [21:0] src37, input  logic [20:0] src38,
  input  logic [19:0] src39, input  logic [18:0] src40, input  logic [17:0] src41,
  input  logic [16:0] src42, input  logic [15:0] src43, input  logic [14:0] src44,
  input  logic [13:0] src45, input  logic [12:0] src46, input  logic [11:0] src47,
  input  logic [10:0] src48, input  logic [9:0]  src49, input  logic [8:0]  src50,
  input  logic [7:0]  src51, input  logic [6:0]  src52, input  logic [5:0]  src53,
  input  logic [4:0]  src54, input  logic [3:0]  src55, input  logic [2:0]  src56,
  input  logic [1:0]  src57, input  logic [0:0]  src58,
  output logic        dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,
  output logic        dst8,  dst9,  dst10, dst11, dst12, dst13, dst14, dst15,
  output logic        dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23,
  output logic        dst24, dst25, dst26, dst27, dst28, dst29, dst30, dst31,
  output logic        dst32, dst33, dst34, dst35, dst36, dst37, dst38, dst39,
  output logic        dst40, dst41, dst42, dst43, dst44, dst45, dst46, dst47,
  output logic        dst48, dst49, dst50, dst51, dst52, dst53, dst54, dst55,
  output logic        dst56, dst57, dst58, dst59
);

  logic [29:0] col_in [60];
  logic [59:0] row_a;
  logic [59:0] row_b;
  logic [59:0] sum_d;
  logic [59:0] sum_q;

  function automatic logic [6:0] col_height(input int k);
    if (k <= 29) begin
      return 7'(k + 1);
    end else if (k <= 58) begin
      return 7'(59 - k);
    end else begin
      return 7'd0;
    end
  endfunction

  assign col_in[0]  = 30'(src0);  assign col_in[1]  = 30'(src1);  assign col_in[2]  = 30'(src2);
  assign col_in[3]  = 30'(src3);  assign col_in[4]  = 30'(src4);  assign col_in[5]  = 30'(src5);
  assign col_in[6]  = 30'(src6);  assign col_in[7]  = 30'(src7);  assign col_in[8]  = 30'(src8);
  assign col_in[9]  = 30'(src9);  assign col_in[10] = 30'(src10); assign col_in[11] = 30'(src11);
  assign col_in[12] = 30'(src12); assign col_in[13] = 30'(src13); assign col_in[14] = 30'(src14);
  assign col_in[15] = 30'(src15); assign col_in[16] = 30'(src16); assign col_in[17] = 30'(src17);
  assign col_in[18] = 30'(src18); assign col_in[19] = 30'(src19); assign col_in[20] = 30'(src20);
  assign col_in[21] = 30'(src21); assign col_in[22] = 30'(src22); assign col_in[23] = 30'(src23);
  assign col_in[24] = 30'(src24); assign col_in[25] = 30'(src25); assign col_in[26] = 30'(src26);
  assign col_in[27] = 30'(src27); assign col_in[28] = 30'(src28); assign col_in[29] = src29;
  assign col_in[30] = 30'(src30); assign col_in[31] = 30'(src31); assign col_in[32] = 30'(src32);
  assign col_in[33] = 30'(src33); assign col_in[34] = 30'(src34); assign col_in[35] = 30'(src35);
  assign col_in[36] = 30'(src36); assign col_in[37] = 30'(src37); assign col_in[38] = 30'(src38);
  assign col_in[39] = 30'(src39); assign col_in[40] = 30'(src40); assign col_in[41] = 30'(src41);
  assign col_in[42] = 30'(src42); assign col_in[43] = 30'(src43); assign col_in[44] = 30'(src44);
  assign col_in[45] = 30'(src45); assign col_in[46] = 30'(src46); assign col_in[47] = 30'(src47);
  assign col_in[48] = 30'(src48); assign col_in[49] = 30'(src49); assign col_in[50] = 30'(src50);
  assign col_in[51] = 30'(src51); assign col_in[52] = 30'(src52); assign col_in[53] = 30'(src53);
  assign col_in[54] = 30'(src54); assign col_in[55] = 30'(src55); assign col_in[56] = 30'(src56);
  assign col_in[57] = 30'(src57); assign col_in[58] = 30'(src58); assign col_in[59] = 30'd0;

  // Each column is packed into a work list (own bits, then carries from k-1) and
  // full adders consume three entries at a time, appending their sum to the list
  // and their carry to column k+1, until at most two entries remain. All indices
  // depend only on the fixed column profile, so the loops unroll to a static tree.
  // Slots past the live region may hold junk; they are never read unmasked.
  always_comb begin
    logic [127:0] w;
    logic [6:0]   rd;
    logic [6:0]   wr;
    logic [6:0]   nfa;
    logic [6:0]   rem;
    logic [31:0]  cy;
    logic [31:0]  nc;
    logic [5:0]   ncy;
    logic [5:0]   nnc;
    logic         en;
    logic         x;
    logic         y;
    logic         z;
    row_a = 60'd0;
    row_b = 60'd0;
    cy    = 32'd0;
    ncy   = 6'd0;
    w     = 128'd0;
    rd    = 7'd0;
    wr    = 7'd0;
    nfa   = 7'd0;
    rem   = 7'd0;
    nc    = 32'd0;
    nnc   = 6'd0;
    en    = 1'b0;
    x     = 1'b0;
    y     = 1'b0;
    z     = 1'b0;
    for (int k = 0; k < 60; k++) begin
      w   = 128'd0;
      rd  = 7'd0;
      wr  = 7'd0;
      nc  = 32'd0;
      nnc = 6'd0;
      for (int b = 0; b < 30; b++) begin
        w[wr] = col_in[6'(k)][5'(b)];
        wr    = wr + ((7'(b) < col_height(k)) ? 7'd1 : 7'd0);
      end
      for (int c = 0; c < 32; c++) begin
        w[wr] = cy[5'(c)];
        wr    = wr + ((6'(c) < ncy) ? 7'd1 : 7'd0);
      end
      nfa = (wr > 7'd2) ? ((wr - 7'd1) >> 1) : 7'd0;
      for (int f = 0; f < 32; f++) begin
        en       = (7'(f) < nfa);
        x        = w[rd];
        y        = w[rd + 7'd1];
        z        = w[rd + 7'd2];
        w[wr]    = x ^ y ^ z;
        nc[nnc[4:0]] = (x & y) | (x & z) | (y & z);
        rd       = rd + (en ? 7'd3 : 7'd0);
        wr       = wr + (en ? 7'd1 : 7'd0);
        nnc      = nnc + (en ? 6'd1 : 6'd0);
      end
      rem = wr - rd;
      row_a[6'(k)] = (rem >= 7'd1) & w[rd];
      row_b[6'(k)] = (rem >= 7'd2) & w[rd + 7'd1];
      cy  = nc;
      ncy = nnc;
    end
  end

  assign sum_d = row_a + row_b;

  // Output register; reset clears the result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 60'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign {dst59, dst58, dst57, dst56, dst55, dst54, dst53, dst52, dst51, dst50,
          dst49, dst48, dst47, dst46, dst45, dst44, dst43, dst42, dst41, dst40,
          dst39, dst38, dst37, dst36, dst35, dst34, dst33, dst32, dst31, dst30,
          dst29, dst28, dst27, dst26, dst25, dst24, dst23, dst22, dst21, dst20,
          dst19, dst18, dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10,
          dst9,  dst8,  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0} = sum_q;

endmodule

// File: tb/tb_compressor_mul30.sv
// Directed-vector and random-stream bench for compressor_mul30.
module tb_compressor_mul30;

  logic        clk;
  logic        rst;
  logic [29:0] tcol [59];
  wire  [59:0] dst;
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [59:0] ALL_ONES_SUM = 60'h0FFF_FFFF_8000_0001;

  typedef struct {
    string       name;
    int          kind;    // 0: single column gets pat, 1: every column all-ones
    int          column;
    logic [29:0] pat;
    logic [59:0] exp;
  } vec_t;

  vec_t vecs [12];

  compressor_mul30 dut (
    .clk(clk), .rst(rst),
    .src0(tcol[0][0:0]),   .src1(tcol[1][1:0]),   .src2(tcol[2][2:0]),   .src3(tcol[3][3:0]),
    .src4(tcol[4][4:0]),   .src5(tcol[5][5:0]),   .src6(tcol[6][6:0]),   .src7(tcol[7][7:0]),
    .src8(tcol[8][8:0]),   .src9(tcol[9][9:0]),   .src10(tcol[10][10:0]), .src11(tcol[11][11:0]),
    .src12(tcol[12][12:0]), .src13(tcol[13][13:0]), .src14(tcol[14][14:0]), .src15(tcol[15][15:0]),
    .src16(tcol[16][16:0]), .src17(tcol[17][17:0]), .src18(tcol[18][18:0]), .src19(tcol[19][19:0]),
    .src20(tcol[20][20:0]), .src21(tcol[21][21:0]), .src22(tcol[22][22:0]), .src23(tcol[23][23:0]),
    .src24(tcol[24][24:0]), .src25(tcol[25][25:0]), .src26(tcol[26][26:0]), .src27(tcol[27][27:0]),
    .src28(tcol[28][28:0]), .src29(tcol[29][29:0]), .src30(tcol[30][28:0]), .src31(tcol[31][27:0]),
    .src32(tcol[32][26:0]), .src33(tcol[33][25:0]), .src34(tcol[34][24:0]), .src35(tcol[35][23:0]),
    .src36(tcol[36][22:0]), .src37(tcol[37][21:0]), .src38(tcol[38][20:0]), .src39(tcol[39][19:0]),
    .src40(tcol[40][18:0]), .src41(tcol[41][17:0]), .src42(tcol[42][16:0]), .src43(tcol[43][15:0]),
    .src44(tcol[44][14:0]), .src45(tcol[45][13:0]), .src46(tcol[46][12:0]), .src47(tcol[47][11:0]),
    .src48(tcol[48][10:0]), .src49(tcol[49][9:0]),  .src50(tcol[50][8:0]),  .src51(tcol[51][7:0]),
    .src52(tcol[52][6:0]),  .src53(tcol[53][5:0]),  .src54(tcol[54][4:0]),  .src55(tcol[55][3:0]),
    .src56(tcol[56][2:0]),  .src57(tcol[57][1:0]),  .src58(tcol[58][0:0]),
    .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),   .dst4(dst[4]),
    .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),   .dst8(dst[8]),   .dst9(dst[9]),
    .dst10(dst[10]), .dst11(dst[11]), .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]),
    .dst15(dst[15]), .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
    .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]), .dst24(dst[24]),
    .dst25(dst[25]), .dst26(dst[26]), .dst27(dst[27]), .dst28(dst[28]), .dst29(dst[29]),
    .dst30(dst[30]), .dst31(dst[31]), .dst32(dst[32]), .dst33(dst[33]), .dst34(dst[34]),
    .dst35(dst[35]), .dst36(dst[36]), .dst37(dst[37]), .dst38(dst[38]), .dst39(dst[39]),
    .dst40(dst[40]), .dst41(dst[41]), .dst42(dst[42]), .dst43(dst[43]), .dst44(dst[44]),
    .dst45(dst[45]), .dst46(dst[46]), .dst47(dst[47]), .dst48(dst[48]), .dst49(dst[49]),
    .dst50(dst[50]), .dst51(dst[51]), .dst52(dst[52]), .dst53(dst[53]), .dst54(dst[54]),
    .dst55(dst[55]), .dst56(dst[56]), .dst57(dst[57]), .dst58(dst[58]), .dst59(dst[59])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] colmask(input int k);
    logic [30:0] m;
    int          h;
    h = (k <= 29) ? k + 1 : 59 - k;
    m = (31'h1 << h) - 31'h1;
    return m[29:0];
  endfunction

  function automatic logic [59:0] model();
    logic [63:0] s;
    s = 64'd0;
    for (int k = 0; k < 59; k++) begin
      s = s + (64'($countones(tcol[k] & colmask(k))) << k);
    end
    return s[59:0];
  endfunction

  task automatic check(input string name, input logic [59:0] act, input logic [59:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %015h expected %015h", name, act, exp);
    end
  endtask

  task automatic set_zero();
    for (int k = 0; k < 59; k++) tcol[k] = 30'd0;
  endtask

  task automatic set_ones();
    for (int k = 0; k < 59; k++) tcol[k] = colmask(k);
  endtask

  initial begin
    vecs[0]  = '{"zeros",        0, 0,  30'h0,        60'h0};
    vecs[1]  = '{"all_ones",     1, 0,  30'h0,        ALL_ONES_SUM};
    vecs[2]  = '{"src29_bit0",   0, 29, 30'h1,        60'h0000_0000_2000_0000};
    vecs[3]  = '{"src58_bit0",   0, 58, 30'h1,        60'h0400_0000_0000_0000};
    vecs[4]  = '{"src1_both",    0, 1,  30'h3,        60'h4};
    vecs[5]  = '{"tall_col29",   0, 29, 30'h3FFF_FFFF, 60'h0000_0003_C000_0000};
    vecs[6]  = '{"src0_bit0",    0, 0,  30'h1,        60'h1};
    vecs[7]  = '{"col30_full",   0, 30, 30'h1FFF_FFFF, 60'h0000_0007_4000_0000};
    vecs[8]  = '{"src57_both",   0, 57, 30'h3,        60'h0400_0000_0000_0000};
    vecs[9]  = '{"src10_two",    0, 10, 30'h5,        60'h800};
    vecs[10] = '{"src2_full",    0, 2,  30'h7,        60'hC};
    vecs[11] = '{"src45_one",    0, 45, 30'h100,      60'h0000_2000_0000_0000};

    rst = 1'b1;
    set_zero();
    #1;
    check("reset_state", dst, 60'h0);
    set_ones();
    repeat (2) @(posedge clk);
    #1;
    check("reset_holds_over_edges", dst, 60'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release_first_edge", dst, ALL_ONES_SUM);

    for (int i = 0; i < 12; i++) begin
      set_zero();
      if (vecs[i].kind == 1) set_ones();
      else tcol[vecs[i].column] = vecs[i].pat & colmask(vecs[i].column);
      @(posedge clk);
      #1;
      check(vecs[i].name, dst, vecs[i].exp);
    end

    // Input changes between edges must not reach dst until the next edge
    set_ones();
    @(posedge clk);
    #1;
    check("load_before_hold", dst, ALL_ONES_SUM);
    #2;
    set_zero();
    #1;
    check("hold_between_edges", dst, ALL_ONES_SUM);
    @(posedge clk);
    #1;
    check("after_hold_edge", dst, 60'h0);

    for (int n = 0; n < 1000; n++) begin
      logic [59:0] e;
      for (int k = 0; k < 59; k++) tcol[k] = 30'($urandom) & colmask(k);
      e = model();
      @(posedge clk);
      #1;
      check("random_stream", dst, e);
    end

    set_ones();
    @(posedge clk);
    #1;
    check("preload_ones", dst, ALL_ONES_SUM);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", dst, 60'h0);
    repeat (2) @(posedge clk);
    #1;
    check("async_reset_held", dst, 60'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("async_release_first_edge", dst, ALL_ONES_SUM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
